// File: rtl/oven_heat_controller.sv
// Oven bake sequencer: IDLE -> PREHEAT -> timed BAKE -> DONE, with cancel and a 2-bit heat loop.
// Optional preheat timeout to FAULT is built when OVEN_PREHEAT_TIMEOUT_EN is defined.
module oven_heat_controller #(
    parameter int TICK_DIV    = 1000,
    parameter int SETTLE_CYC  = 4,
    parameter int FAST_BAND   = 20,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cancel,
    input  logic [9:0]  targetTemp,
    input  logic [15:0] bakeTicks,
    input  logic [9:0]  currentTemp,
    output logic [1:0]  heat,
    output logic        preheated,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [15:0] remaining,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREHEAT = 3'd1,
        BAKE    = 3'd2,
        DONE    = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam int PW = $clog2(TICK_DIV) + 1;
    localparam int SW = $clog2(SETTLE_CYC) + 1;
    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
    localparam logic signed [10:0] FAST   = 11'(FAST_BAND);

    state_t             st_q, st_d;
    logic [9:0]         tgt_q, tgt_d;
    logic [15:0]        rem_q, rem_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [SW-1:0]      set_q, set_d;
    logic signed [10:0] err;
    logic               accept, in_band, settled, timeout;
    logic [1:0]         heat_rule;

    assign accept  = (st_q == IDLE) && start && !cancel;
    assign tgt_d   = accept ? ((targetTemp > 10'd511) ? 10'd511 : targetTemp) : tgt_q;
    // Error is taken against the target that will be held after this edge, so the
    // first PREHEAT cycle already regulates toward the newly latched target.
    assign err     = $signed({1'b0, tgt_d}) - $signed({1'b0, currentTemp});
    assign in_band = (err >= -11'sd2) && (err <= 11'sd2);
    assign settled = in_band && (set_q >= SETTLE_LAST);

    always_comb begin
        heat_rule = 2'd0;
        if (err > FAST)        heat_rule = 2'd3;
        else if (err > 11'sd2) heat_rule = 2'd2;
        else if (err >= 11'sd0) heat_rule = 2'd1;
    end

`ifdef OVEN_PREHEAT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tmo_q <= '0;
        else if (st_q != PREHEAT)  tmo_q <= '0;
        else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + 1'b1;
    end
    assign timeout = (st_q == PREHEAT) && (tmo_q == TMO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_d  = st_q;
        rem_d = rem_q;
        pre_d = pre_q;
        set_d = set_q;
        case (st_q)
            IDLE: if (accept) begin
                rem_d = bakeTicks;
                pre_d = '0;
                set_d = '0;
                st_d  = PREHEAT;
            end
            PREHEAT: begin
                if (!in_band)              set_d = '0;
                else if (set_q < SETTLE_MAX) set_d = set_q + 1'b1;
                // Settling wins over a coincident timeout.
                if (settled)      st_d = (rem_q == 16'd0) ? DONE : BAKE;
                else if (timeout) st_d = FAULT;
            end
            BAKE: begin
                if (pre_q >= PRE_LAST) begin
                    pre_d = '0;
                    if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
                    if (rem_q <= 16'd1) st_d = DONE;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            DONE:    st_d = IDLE;
            FAULT:   st_d = FAULT;
            default: st_d = IDLE;
        endcase
        if (cancel && (st_q != IDLE)) begin
            st_d  = IDLE;
            rem_d = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= IDLE;
            tgt_q     <= '0;
            rem_q     <= '0;
            pre_q     <= '0;
            set_q     <= '0;
            heat      <= 2'd0;
            preheated <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            st_q      <= st_d;
            tgt_q     <= tgt_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            set_q     <= set_d;
            heat      <= ((st_d == PREHEAT) || (st_d == BAKE)) ? heat_rule : 2'd0;
            preheated <= (st_d == BAKE);
            busy      <= (st_d == PREHEAT) || (st_d == BAKE);
            done      <= (st_d == DONE);
            fault     <= (st_d == FAULT);
        end
    end

    assign remaining = rem_q;
    assign state     = st_q;
endmodule

// File: tb/tb_oven_heat_controller.sv
// Scoreboard bench for oven_heat_controller: per-cycle expectations queued at drive, checked after each edge.
module tb_oven_heat_controller;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [9:0]  targetTemp = '0, currentTemp = '0;
    logic [15:0] bakeTicks = '0;
    logic [1:0]  heat;
    logic        preheated, busy, done, fault;
    logic [15:0] remaining;
    logic [2:0]  state;

    always #5 clk = ~clk;

    oven_heat_controller #(.TICK_DIV(4), .SETTLE_CYC(4), .FAST_BAND(20), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
        .targetTemp(targetTemp), .bakeTicks(bakeTicks), .currentTemp(currentTemp),
        .heat(heat), .preheated(preheated), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining), .state(state)
    );

    int n_run = 0, n_fail = 0;
    typedef struct { string tag; logic [24:0] exp; } sb_t;
    sb_t sb[$];
    wire [24:0] obs = {state, heat, preheated, busy, done, fault, remaining};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // {state, heat, preheated, busy, done, fault, remaining}
    function automatic logic [24:0] ex(input int st, input int h, input int rem);
        logic [2:0] s = 3'(st);
        return {s, 2'(h), s == 3'd2, (s == 3'd1) || (s == 3'd2), s == 3'd3, s == 3'd4, 16'(rem)};
    endfunction

    function automatic int href(input int e);
        if (e > 20) return 3;
        if (e > 2)  return 2;
        if (e >= 0) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : mon
        sb_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, 32'(obs), 32'(e.exp));
        end
    end

    task automatic cyc(input string tag, input logic s, input logic c, input int tgt,
                       input int ticks, input int cur, input logic [24:0] e);
        @(negedge clk);
        start       = s;
        cancel      = c;
        targetTemp  = 10'(tgt);
        bakeTicks   = 16'(ticks);
        currentTemp = 10'(cur);
        sb.push_back('{tag, e});
    endtask

    initial begin
        int tv [0:8];
        int hv [0:8];
        #2;
        check("reset_state", 32'(obs), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp 65 -> 200, bake 3 ticks of 4 clocks
        cyc("ramp_start", 1, 0, 200, 3, 65, ex(1, 3, 3));
        for (int c = 66; c <= 200; c++) cyc("ramp_pre", 0, 0, 200, 3, c, ex(1, href(200 - c), 3));
        cyc("ramp_bake_in", 0, 0, 200, 3, 200, ex(2, 1, 3));
        for (int k = 1; k <= 11; k++) cyc("ramp_bake", 0, 0, 200, 3, 200, ex(2, 1, 3 - k / 4));
        cyc("ramp_done", 0, 0, 200, 3, 200, ex(3, 0, 0));
        cyc("ramp_idle", 0, 0, 200, 3, 200, ex(0, 0, 0));

        // Target clamp to 511 and zero bake time going straight to DONE
        cyc("clamp_start", 1, 0, 700, 0, 511, ex(1, 1, 0));
        for (int k = 0; k < 3; k++) cyc("clamp_pre", 0, 0, 700, 0, 511, ex(1, 1, 0));
        cyc("clamp_done", 0, 0, 700, 0, 511, ex(3, 0, 0));
        cyc("clamp_idle", 0, 0, 700, 0, 511, ex(0, 0, 0));

        // Overshoot in BAKE gives heat 0; cancel coincident with tick expiry
        cyc("cx_start", 1, 0, 200, 1, 200, ex(1, 1, 1));
        for (int k = 0; k < 3; k++) cyc("cx_pre", 0, 0, 200, 1, 200, ex(1, 1, 1));
        cyc("cx_bake", 0, 0, 200, 1, 200, ex(2, 1, 1));
        for (int k = 0; k < 3; k++) cyc("cx_hot", 0, 0, 200, 1, 205, ex(2, 0, 1));
        cyc("cx_cancel", 0, 1, 200, 1, 205, ex(0, 0, 0));
        cyc("cx_idle", 0, 0, 200, 1, 205, ex(0, 0, 0));

        // start ignored while busy; cancel beats start in IDLE
        cyc("ig_start", 1, 0, 200, 2, 100, ex(1, 3, 2));
        cyc("ig_restart", 1, 0, 150, 9, 160, ex(1, 3, 2));
        cyc("ig_hold", 0, 0, 150, 9, 190, ex(1, 2, 2));
        cyc("ig_cancel", 0, 1, 150, 9, 190, ex(0, 0, 0));
        cyc("ig_both", 1, 1, 150, 9, 190, ex(0, 0, 0));
        cyc("ig_cnl_idle", 0, 1, 150, 9, 190, ex(0, 0, 0));
        cyc("ig_idle", 0, 0, 150, 9, 190, ex(0, 0, 0));

        // Heat thresholds and settle counter restart after leaving the band
        tv = '{280, 297, 298, 300, 301, 305, 300, 300, 300};
        hv = '{2, 2, 1, 1, 0, 0, 1, 1, 1};
        cyc("hb_start", 1, 0, 300, 5, 279, ex(1, 3, 5));
        for (int k = 0; k < 9; k++) cyc("hb_pre", 0, 0, 300, 5, tv[k], ex(1, hv[k], 5));
        cyc("hb_bake", 0, 0, 300, 5, 300, ex(2, 1, 5));
        cyc("hb_cancel", 0, 1, 300, 5, 300, ex(0, 0, 0));

        // Asynchronous reset in the middle of a bake
        cyc("rst_start", 1, 0, 200, 5, 200, ex(1, 1, 5));
        for (int k = 0; k < 3; k++) cyc("rst_pre", 0, 0, 200, 5, 200, ex(1, 1, 5));
        for (int k = 0; k < 3; k++) cyc("rst_bake", 0, 0, 200, 5, 200, ex(2, 1, 5));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(obs), 32'(0));
        @(posedge clk);
        #2 check("rst_hold", 32'(obs), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_idle", 0, 0, 200, 5, 200, ex(0, 0, 0));

        // Preheat that never reaches the band
        cyc("tmo_start", 1, 0, 200, 3, 65, ex(1, 3, 3));
`ifdef OVEN_PREHEAT_TIMEOUT_EN
        for (int k = 1; k < 50; k++) cyc("tmo_pre", 0, 0, 200, 3, 65, ex(1, 3, 3));
        cyc("tmo_fault", 0, 0, 200, 3, 65, ex(4, 0, 3));
        cyc("tmo_stay", 1, 0, 200, 3, 65, ex(4, 0, 3));
`else
        for (int k = 1; k <= 60; k++) cyc("tmo_pre", 0, 0, 200, 3, 65, ex(1, 3, 3));
`endif
        cyc("tmo_cancel", 0, 1, 200, 3, 65, ex(0, 0, 0));
        cyc("tmo_idle", 0, 0, 200, 3, 65, ex(0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
